// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the native-interface memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned N   = 2,
  parameter int unsigned IDW = 1
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;

  // Rotating a doubled copy puts the port at ptr_i in bit 0.
  assign req_dbl = {req_i, req_i};
  assign req_rot = N'(req_dbl >> ptr_i);

  always_comb begin
    int unsigned sel;
    sel   = 0;
    any_o = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!any_o && req_rot[k]) begin
        any_o = 1'b1;
        sel   = 32'(ptr_i) + k;
      end
    end
    if (sel >= N) sel = sel - N;
    idx_o = IDW'(sel);
    gnt_o = any_o ? (N'(1) << sel) : '0;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-to-1 round-robin arbiter for the picorv32 native memory interface,
// with registered non-overlapping transfers and a bus-timeout watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned       NUM_PORTS      = 2,
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       TIMEOUT_CYCLES = 256,
  parameter logic [DATA_W-1:0] ERR_RDATA      = DATA_W'(DEFAULT_ERR_RDATA)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0]                 s_valid,
  input  logic [NUM_PORTS-1:0]                 s_instr,
  input  logic [NUM_PORTS*ADDR_W-1:0]          s_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]          s_wdata,
  input  logic [NUM_PORTS*DATA_W/8-1:0]        s_wstrb,
  output logic [NUM_PORTS-1:0]                 s_ready,
  output logic [DATA_W-1:0]                    s_rdata,
  output logic                                 mem_valid,
  output logic                                 mem_instr,
  input  logic                                 mem_ready,
  output logic [ADDR_W-1:0]                    mem_addr,
  output logic [DATA_W-1:0]                    mem_wdata,
  output logic [DATA_W/8-1:0]                  mem_wstrb,
  input  logic [DATA_W-1:0]                    mem_rdata,
  output logic [clog2_min1(NUM_PORTS)-1:0]     grant_id,
  output logic                                 bus_err,
  output logic [clog2_min1(NUM_PORTS)-1:0]     err_port
);

  localparam int unsigned IDW = clog2_min1(NUM_PORTS);
  localparam int unsigned SW  = DATA_W / 8;

  state_e                 state_q;
  logic [IDW-1:0]         ptr_q, ptr_d, grant_q, err_port_q;
  logic [NUM_PORTS-1:0]   gnt_oh_q, s_ready_q;
  logic [31:0]            wait_cnt_q;
  logic                   mem_valid_q, mem_instr_q, bus_err_q;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic [DATA_W-1:0]      mem_wdata_q, s_rdata_q;
  logic [SW-1:0]          mem_wstrb_q;

  logic [NUM_PORTS-1:0]   pick_gnt;
  logic [IDW-1:0]         pick_idx;
  logic                   pick_any;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic [SW-1:0]          sel_wstrb;
  logic                   sel_instr;
  logic                   timeout_hit;

  // A port completing this cycle still shows valid; masking it stops a re-grant.
  rr_pick #(
    .N   (NUM_PORTS),
    .IDW (IDW)
  ) u_pick (
    .req_i (s_valid & ~s_ready_q),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    sel_instr = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (pick_gnt[i]) begin
        sel_addr  = s_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = s_wdata[i*DATA_W +: DATA_W];
        sel_wstrb = s_wstrb[i*SW +: SW];
        sel_instr = s_instr[i];
      end
    end
  end

  assign ptr_d       = (grant_q == IDW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      gnt_oh_q    <= '0;
      wait_cnt_q  <= '0;
      mem_valid_q <= 1'b0;
      mem_instr_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      s_ready_q   <= '0;
      s_rdata_q   <= '0;
      bus_err_q   <= 1'b0;
      err_port_q  <= '0;
    end else begin
      s_ready_q <= '0;
      bus_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q     <= BUSY;
            mem_valid_q <= 1'b1;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_wstrb_q <= sel_wstrb;
            mem_instr_q <= sel_instr;
            grant_q     <= pick_idx;
            gnt_oh_q    <= pick_gnt;
            wait_cnt_q  <= '0;
          end
        end
        BUSY: begin
          wait_cnt_q <= wait_cnt_q + 32'd1;
          // mem_ready takes priority when it coincides with the timeout threshold.
          if (mem_ready || timeout_hit) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            s_ready_q   <= gnt_oh_q;
            ptr_q       <= ptr_d;
            if (mem_ready) begin
              s_rdata_q <= mem_rdata;
            end else begin
              s_rdata_q  <= ERR_RDATA;
              bus_err_q  <= 1'b1;
              err_port_q <= grant_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready   = s_ready_q;
  assign s_rdata   = s_rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_instr = mem_instr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign grant_id  = grant_q;
  assign bus_err   = bus_err_q;
  assign err_port  = err_port_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;
  localparam logic [DW-1:0] ERRV = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [N-1:0]     s_valid, s_instr, s_ready;
  logic [N*AW-1:0]  s_addr;
  logic [N*DW-1:0]  s_wdata;
  logic [N*SW-1:0]  s_wstrb;
  logic [DW-1:0]    s_rdata, mem_wdata, mem_rdata;
  logic             mem_valid, mem_instr, mem_ready, bus_err;
  logic [AW-1:0]    mem_addr;
  logic [SW-1:0]    mem_wstrb;
  logic [1:0]       grant_id, err_port;

  mem_port_arbiter #(
    .NUM_PORTS      (N),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO),
    .ERR_RDATA      (ERRV)
  ) dut (
    .clk (clk), .reset (reset),
    .s_valid (s_valid), .s_instr (s_instr), .s_addr (s_addr), .s_wdata (s_wdata),
    .s_wstrb (s_wstrb), .s_ready (s_ready), .s_rdata (s_rdata),
    .mem_valid (mem_valid), .mem_instr (mem_instr), .mem_ready (mem_ready),
    .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata), .grant_id (grant_id), .bus_err (bus_err), .err_port (err_port)
  );

  // Second instance with the watchdog disabled.
  logic [1:0]  z_valid, z_instr, z_ready;
  logic [63:0] z_addr, z_wdata;
  logic [7:0]  z_wstrb;
  logic [31:0] z_rdata, z_mwdata, z_maddr;
  logic        z_mvalid, z_minstr, z_bus_err;
  logic [3:0]  z_mwstrb;
  logic [0:0]  z_grant, z_err_port;

  mem_port_arbiter #(
    .NUM_PORTS      (2),
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (0)
  ) dut_nowd (
    .clk (clk), .reset (reset),
    .s_valid (z_valid), .s_instr (z_instr), .s_addr (z_addr), .s_wdata (z_wdata),
    .s_wstrb (z_wstrb), .s_ready (z_ready), .s_rdata (z_rdata),
    .mem_valid (z_mvalid), .mem_instr (z_minstr), .mem_ready (1'b0),
    .mem_addr (z_maddr), .mem_wdata (z_mwdata), .mem_wstrb (z_mwstrb),
    .mem_rdata (32'h0), .grant_id (z_grant), .bus_err (z_bus_err), .err_port (z_err_port)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: which port owns the bus, how long it has waited, whose turn is next.
  bit            m_busy;
  int            m_port, m_waited, m_next;
  logic [N-1:0]  e_sready;
  logic          e_mvalid, e_err, e_instr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;
  logic [SW-1:0] e_wstrb;
  int            e_grant, e_errport;

  function automatic void model_reset();
    m_busy = 0; m_port = 0; m_waited = 0; m_next = 0;
    e_sready = '0; e_mvalid = 0; e_err = 0; e_instr = 0;
    e_addr = '0; e_wdata = '0; e_rdata = '0; e_wstrb = '0;
    e_grant = 0; e_errport = 0;
  endfunction

  function automatic void model_step();
    logic [N-1:0] want;
    logic [N-1:0] nxt_ready;
    logic         nxt_err;
    int           p;
    nxt_ready = '0;
    nxt_err   = 1'b0;
    if (!m_busy) begin
      want = s_valid & ~e_sready;
      for (int k = 0; k < N; k++) begin
        p = (m_next + k) % N;
        if (!m_busy && want[p]) begin
          m_busy = 1; m_port = p; m_waited = 0;
          e_mvalid = 1'b1; e_grant = p;
          e_addr  = s_addr[p*AW +: AW];
          e_wdata = s_wdata[p*DW +: DW];
          e_wstrb = s_wstrb[p*SW +: SW];
          e_instr = s_instr[p];
        end
      end
    end else begin
      m_waited++;
      if (mem_ready || m_waited == TO) begin
        nxt_ready[m_port] = 1'b1;
        m_busy = 0; e_mvalid = 1'b0;
        m_next = (m_port + 1) % N;
        if (mem_ready) e_rdata = mem_rdata;
        else begin e_rdata = ERRV; nxt_err = 1'b1; e_errport = m_port; end
      end
    end
    e_sready = nxt_ready;
    e_err    = nxt_err;
  endfunction

  task automatic compare_all();
    chk("mem_valid", mem_valid, e_mvalid);
    chk("s_ready", s_ready, e_sready);
    chk("bus_err", bus_err, e_err);
    chk("s_rdata", s_rdata, e_rdata);
    chk("grant_id", grant_id, e_grant);
    chk("err_port", err_port, e_errport);
    if (e_mvalid) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("mem_wstrb", mem_wstrb, e_wstrb);
      chk("mem_instr", mem_instr, e_instr);
    end
  endtask

  // Memory responder: cfg_wait < 0 means random readiness and data.
  int            cfg_wait;
  logic [DW-1:0] cfg_rdata;
  int            bcnt;

  task automatic step(input bit check);
    if (mem_valid) begin
      mem_ready = (cfg_wait < 0) ? ($urandom_range(0, 4) == 0) : (bcnt == cfg_wait);
      bcnt++;
    end else begin
      mem_ready = 1'b0;
      bcnt = 0;
    end
    mem_rdata = (cfg_wait < 0) ? DW'($urandom) : cfg_rdata;
    model_step();
    @(posedge clk);
    #1;
    if (check) compare_all();
  endtask

  task automatic new_req(input int i);
    s_addr[i*AW +: AW]  = $urandom;
    s_wdata[i*DW +: DW] = $urandom;
    s_wstrb[i*SW +: SW] = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom);
    s_instr[i]          = 1'($urandom_range(0, 1));
    s_valid[i]          = 1'b1;
  endtask

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    int          wait_c;
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int lat;
    bit got;
    int ord[$];
    int cnt0, cnt1, zb_valid, zb_ready, zb_err;

    tbl[0] = '{0, 32'h100, 32'h0,        4'h0, 1'b0, 3,    32'h1234_5678, 32'h1234_5678, 1'b0, 5};
    tbl[1] = '{1, 32'h200, 32'hCAFE_F00D, 4'hF, 1'b0, 1000, 32'h0,         32'hDEAD_BEEF, 1'b1, 17};
    tbl[2] = '{2, 32'h300, 32'h0,        4'h0, 1'b1, 0,    32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b0, 2};
    tbl[3] = '{0, 32'h400, 32'h0,        4'h0, 1'b0, 15,   32'h0BAD_CAFE, 32'h0BAD_CAFE, 1'b0, 17};
    tbl[4] = '{1, 32'h500, 32'h1122_3344, 4'h3, 1'b0, 14,   32'h5555_AAAA, 32'h5555_AAAA, 1'b0, 16};
    tbl[5] = '{2, 32'h600, 32'h0000_0077, 4'h1, 1'b0, 16,   32'h0000_0099, 32'hDEAD_BEEF, 1'b1, 17};

    reset = 1'b1;
    s_valid = '0; s_instr = '0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    z_valid = '0; z_instr = '0; z_addr = '0; z_wdata = '0; z_wstrb = '0;
    cfg_wait = -1; cfg_rdata = '0; bcnt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_mem_instr", mem_instr, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_s_rdata", s_rdata, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_err_port", err_port, 0);
    reset = 1'b0;

    // Directed single-port transfers
    foreach (tbl[v]) begin
      s_valid = '0;
      s_addr[tbl[v].port*AW +: AW]  = tbl[v].addr;
      s_wdata[tbl[v].port*DW +: DW] = tbl[v].wdata;
      s_wstrb[tbl[v].port*SW +: SW] = tbl[v].wstrb;
      s_instr[tbl[v].port]          = tbl[v].instr;
      s_valid[tbl[v].port]          = 1'b1;
      cfg_wait  = tbl[v].wait_c;
      cfg_rdata = tbl[v].rdata;
      lat = 0; got = 0;
      while (!got && lat < 60) begin
        step(1);
        lat++;
        if (s_ready[tbl[v].port]) got = 1;
      end
      chk("vec_done", got, 1);
      chk("vec_latency", lat, tbl[v].exp_lat);
      chk("vec_rdata", s_rdata, tbl[v].exp_rdata);
      chk("vec_bus_err", bus_err, tbl[v].exp_err);
      if (tbl[v].exp_err) chk("vec_err_port", err_port, tbl[v].port);
      s_valid = '0;
      step(1);
    end

    // Fairness: ports 0 and 1 request back-to-back from pointer 0
    reset = 1'b1; #1; model_reset();
    @(posedge clk); #1; reset = 1'b0;
    s_valid = '0; new_req(0); new_req(1);
    cfg_wait = 1; cfg_rdata = 32'h0F0F_0F0F;
    cnt0 = 0; cnt1 = 0;
    for (int c = 0; c < 100 && ord.size() < 8; c++) begin
      step(1);
      if (s_ready[0]) begin ord.push_back(0); cnt0++; new_req(0); end
      if (s_ready[1]) begin ord.push_back(1); cnt1++; new_req(1); end
    end
    chk("rr_transfers", ord.size(), 8);
    foreach (ord[i]) chk("rr_order", ord[i], i % 2);
    chk("rr_count_p0", cnt0, 4);
    chk("rr_count_p1", cnt1, 4);
    s_valid = '0;
    for (int c = 0; c < 20 && mem_valid; c++) step(1);
    step(1);

    // Asynchronous reset during a stalled transfer on port 1
    new_req(1); cfg_wait = 1000;
    repeat (5) step(1);
    chk("pre_rst_grant", grant_id, 1);
    chk("pre_rst_valid", mem_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_mem_valid", mem_valid, 0);
    chk("async_s_ready", s_ready, 0);
    chk("async_grant_id", grant_id, 0);
    model_reset();
    @(posedge clk); #1; reset = 1'b0;
    cfg_wait = 2; cfg_rdata = 32'h600D_D00D;
    step(1);
    chk("post_rst_grant", grant_id, 1);
    chk("post_rst_valid", mem_valid, 1);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      step(1);
      if (s_ready[1]) got = 1;
    end
    chk("post_rst_done", got, 1);
    s_valid = '0;
    step(1);

    // Randomized traffic, including protocol-violating early drops
    cfg_wait = -1;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (s_valid[i] && s_ready[i]) begin
          if ($urandom_range(0, 1) == 0) s_valid[i] = 1'b0;
          else new_req(i);
        end else if (!s_valid[i] && $urandom_range(0, 2) == 0) begin
          new_req(i);
        end else if (s_valid[i] && $urandom_range(0, 49) == 0) begin
          s_valid[i] = 1'b0;
        end
      end
      step(1);
    end
    s_valid = '0;
    mem_ready = 1'b0;

    // Watchdog disabled: a stalled transfer must hold indefinitely
    z_addr = 64'h0000_0000_0000_0ABC; z_valid = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    chk("nowd_grant_valid", z_mvalid, 1);
    chk("nowd_addr", z_maddr, 32'h0ABC);
    zb_valid = 0; zb_ready = 0; zb_err = 0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      #1;
      if (!z_mvalid) zb_valid++;
      if (z_ready != 0) zb_ready++;
      if (z_bus_err) zb_err++;
    end
    chk("nowd_valid_drops", zb_valid, 0);
    chk("nowd_s_ready", zb_ready, 0);
    chk("nowd_bus_err", zb_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
